// File: rtl/branch_sequencer.sv
// branch_sequencer: owns the program counter and sequences branch-target
// generation through the external registered shift-left-by-2 unit.
// A branch takes three cycles: accept (IDLE), SHIFT, RESOLVE. The external
// unit samples se_to_shift at the end of SHIFT, so sl_out is valid in RESOLVE.
// Optional feature: define BRANCH_STATS_EN to add the saturating
// br_count / taken_count outputs.
module branch_sequencer #(
  parameter int unsigned PC_STEP  = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [1:0]  br_op,
  input  logic [15:0] se_imm,
  input  logic        zero,
  input  logic        stall,
  output logic [15:0] se_to_shift,
  input  logic [15:0] sl_out,
  output logic [15:0] pc,
  output logic        fetch_en,
  output logic        busy,
`ifdef BRANCH_STATS_EN
  output logic [15:0] br_count,
  output logic [15:0] taken_count,
`endif
  output logic        flush
);

  localparam logic [1:0]  OP_NONE = 2'b00;
  localparam logic [1:0]  OP_BEQ  = 2'b01;
  localparam logic [1:0]  OP_BNE  = 2'b10;
  localparam logic [1:0]  OP_JUMP = 2'b11;
  localparam logic [15:0] STEP    = 16'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] se_q;
  logic [1:0]  op_q;
  logic [15:0] pc_next_q;
  logic        flush_q;
  logic        busy_q;
  logic        fetch_en_q;

  logic [15:0] pc_inc_d;
  logic [15:0] target_d;
  logic        taken_d;

  // Branch condition evaluated against the ALU zero flag in RESOLVE.
  function automatic logic branch_taken(input logic [1:0] op, input logic z);
    case (op)
      OP_BEQ:  return z;
      OP_BNE:  return ~z;
      OP_JUMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 16-bit counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sequential PC and branch target; both wrap modulo 2^16.
  always_comb begin
    pc_inc_d = pc_q + STEP;
    target_d = pc_next_q + sl_out;
    taken_d  = branch_taken(op_q, zero);
  end

  // Sequencer FSM with registered outputs; stall freezes everything but flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      se_q       <= 16'h0000;
      op_q       <= OP_NONE;
      pc_next_q  <= 16'h0000;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      fetch_en_q <= 1'b1;
    end else begin
      flush_q <= 1'b0;
      if (!stall) begin
        case (state_q)
          IDLE: begin
            if (instr_valid) begin
              if (br_op == OP_NONE) begin
                pc_q <= pc_inc_d;
              end else begin
                se_q       <= se_imm;
                op_q       <= br_op;
                pc_next_q  <= pc_inc_d;
                state_q    <= SHIFT;
                busy_q     <= 1'b1;
                fetch_en_q <= 1'b0;
              end
            end
          end
          SHIFT: begin
            state_q <= RESOLVE;
          end
          RESOLVE: begin
            pc_q       <= taken_d ? target_d : pc_next_q;
            flush_q    <= taken_d;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            fetch_en_q <= 1'b1;
          end
          default: begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            fetch_en_q <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] br_count_q;
  logic [15:0] taken_count_q;

  // Count resolved branches and taken branches on each non-stalled RESOLVE exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q    <= 16'h0000;
      taken_count_q <= 16'h0000;
    end else if (!stall && state_q == RESOLVE) begin
      br_count_q <= sat_inc(br_count_q);
      if (taken_d) begin
        taken_count_q <= sat_inc(taken_count_q);
      end
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`endif

  assign se_to_shift = se_q;
  assign pc          = pc_q;
  assign fetch_en    = fetch_en_q;
  assign busy        = busy_q;
  assign flush       = flush_q;

endmodule
